// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int DEFAULT_SCAN_DIV     = 1000;
  localparam int DEFAULT_DEBOUNCE_CNT = 8;

  // Hex code for each key, indexed by {row, col}. '*' maps to E, '#' to F.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Index of the lowest-numbered active-low row (0 when none is low).
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    lowest_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) lowest_low = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Generic W-bit two-flop synchronizer for asynchronous inputs.
// Resets to RST_VAL so idle (pulled-up) lines read inactive after reset.
module sync2 #(
  parameter int W = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops; only q is used by downstream logic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: drives one column low at a time,
// freezes on a detected press, debounces it, and emits one hex code with a
// single-cycle key_valid pulse per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = DEFAULT_SCAN_DIV,
  parameter int DEBOUNCE_CNT = DEFAULT_DEBOUNCE_CNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

  logic [3:0]       row_s;
  logic [DIV_W-1:0] div;
  logic             tick;

  state_t           state, state_nxt;
  logic [1:0]       col_idx, col_idx_nxt;
  logic [1:0]       row_cap, row_cap_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]       key_nxt;
  logic             valid_nxt, held_nxt;
  logic             cap_low;

  sync2 #(.W(4), .RST_VAL(4'hF)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (row_s)
  );

  assign tick    = (div == DIV_W'(SCAN_DIV - 1));
  assign col     = ~(4'b0001 << col_idx);
  assign cap_low = ~row_s[row_cap];
  assign cnt_inc = cnt + CNT_W'(1);

  // Free-running scan divider; the last count is the scan tick.
  always_ff @(posedge clk) begin
    if (!reset)    div <= '0;
    else if (tick) div <= '0;
    else           div <= div + DIV_W'(1);
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_cap   <= 2'd0;
      cnt       <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_idx_nxt;
      row_cap   <= row_cap_nxt;
      cnt       <= cnt_nxt;
      key       <= key_nxt;
      key_valid <= valid_nxt;
      key_held  <= held_nxt;
    end
  end

  // Next-state logic, evaluated only on scan ticks. While frozen, only the
  // captured row in the captured column is looked at.
  always_comb begin
    state_nxt   = state;
    col_idx_nxt = col_idx;
    row_cap_nxt = row_cap;
    cnt_nxt     = cnt;
    key_nxt     = key;
    valid_nxt   = 1'b0;
    held_nxt    = key_held;
    if (tick) begin
      case (state)
        SCAN: begin
          if (row_s != 4'hF) begin
            row_cap_nxt = lowest_low(row_s);
            cnt_nxt     = CNT_W'(1);
            if (DEBOUNCE_CNT == 1) begin
              key_nxt   = KEY_MAP[{lowest_low(row_s), col_idx}];
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
              state_nxt = HELD;
            end else begin
              state_nxt = DEBOUNCE;
            end
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (cap_low) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
              key_nxt   = KEY_MAP[{row_cap, col_idx}];
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
              state_nxt = HELD;
            end
          end else begin
            cnt_nxt     = '0;
            col_idx_nxt = col_idx + 2'd1;
            state_nxt   = SCAN;
          end
        end
        HELD: begin
          if (!cap_low) begin
            cnt_nxt = CNT_W'(1);
            if (DEBOUNCE_CNT == 1) begin
              held_nxt    = 1'b0;
              col_idx_nxt = col_idx + 2'd1;
              state_nxt   = SCAN;
            end else begin
              state_nxt = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (!cap_low) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
              held_nxt    = 1'b0;
              col_idx_nxt = col_idx + 2'd1;
              state_nxt   = SCAN;
            end
          end else begin
            state_nxt = HELD;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a keypad model, a tick-level
// reference model of the scanner, and an expected-key queue.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row = 4'hF;
  logic [3:0] col, key;
  logic       key_valid, key_held;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Clock block
  always #5 clk = ~clk;

  // Physical keypad: pressed[r][c] shorts row r to column c.
  bit pressed [4][4];

  int  checks = 0;
  int  errors = 0;
  int  pulses = 0;
  bit  check_en = 1'b0;
  logic [3:0] exp_q [$];

  // Reference model state: scan position, whether a key is locked, whether
  // it has been accepted, and the run of consecutive confirming ticks.
  int         m_div, m_col, m_row, m_run;
  bit         m_locked, m_held, m_valid;
  logic [3:0] m_key;

  function automatic logic [3:0] keypad_rows(input logic [3:0] c);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (pressed[i][j] && c[j] == 1'b0) r[i] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] key_code(input int r, input int c);
    if (c == 3) return (r == 3) ? 4'hD : 4'(10 + r);
    if (r == 3) return (c == 0) ? 4'hE : ((c == 1) ? 4'h0 : 4'hF);
    return 4'(3 * r + c + 1);
  endfunction

  task automatic model_reset();
    m_div = 0; m_col = 0; m_row = 0; m_run = 0;
    m_locked = 0; m_held = 0; m_valid = 0; m_key = 4'h0;
    exp_q.delete();
  endtask

  task automatic model_accept();
    m_key   = key_code(m_row, m_col);
    m_valid = 1;
    m_held  = 1;
    m_run   = 0;
    exp_q.push_back(m_key);
  endtask

  // One scan tick of the reference model.
  task automatic model_tick();
    int first;
    if (!m_locked) begin
      first = -1;
      for (int r = 3; r >= 0; r--) if (pressed[r][m_col]) first = r;
      if (first >= 0) begin
        m_locked = 1; m_row = first; m_run = 1;
        if (m_run == DB) model_accept();
      end else begin
        m_col = (m_col + 1) % 4;
      end
    end else if (!m_held) begin
      if (pressed[m_row][m_col]) begin
        m_run++;
        if (m_run == DB) model_accept();
      end else begin
        m_locked = 0; m_run = 0;
        m_col = (m_col + 1) % 4;
      end
    end else begin
      if (pressed[m_row][m_col]) m_run = 0;
      else begin
        m_run++;
        if (m_run == DB) begin
          m_held = 0; m_locked = 0; m_run = 0;
          m_col = (m_col + 1) % 4;
        end
      end
    end
  endtask

  // Advance one clock, update the model, compare outputs, scoreboard pulses.
  task automatic cycle();
    bit was_tick, in_reset;
    logic [3:0] exp_col, got_key;
    was_tick = (m_div == SCAN_DIV - 1);
    in_reset = (reset == 1'b0);
    @(posedge clk);
    #1;
    m_valid = 0;
    if (in_reset) model_reset();
    else begin
      if (was_tick) model_tick();
      m_div = (m_div + 1) % SCAN_DIV;
    end
    if (check_en) begin
      exp_col = 4'b0001 << m_col;
      exp_col = ~exp_col;
      checks++;
      if (col !== exp_col) begin
        errors++; $display("FAIL col: got %b expected %b at %0t", col, exp_col, $time);
      end
      checks++;
      if (key !== m_key) begin
        errors++; $display("FAIL key: got %h expected %h at %0t", key, m_key, $time);
      end
      checks++;
      if (key_valid !== m_valid) begin
        errors++; $display("FAIL key_valid: got %b expected %b at %0t", key_valid, m_valid, $time);
      end
      checks++;
      if (key_held !== m_held) begin
        errors++; $display("FAIL key_held: got %b expected %b at %0t", key_held, m_held, $time);
      end
      if (key_valid === 1'b1) begin
        pulses++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sb_pulse: got key %h expected no pulse at %0t", key, $time);
        end else begin
          got_key = exp_q.pop_front();
          if (key !== got_key) begin
            errors++; $display("FAIL sb_key: got %h expected %h at %0t", key, got_key, $time);
          end
        end
      end
    end
    row = keypad_rows(col);
  endtask

  // Driver tasks
  task automatic set_key(input int r, input int c, input bit v);
    pressed[r][c] = v;
    row = keypad_rows(col);
  endtask

  task automatic release_all();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) pressed[i][j] = 0;
    row = keypad_rows(col);
  endtask

  // Returns right after the n-th tick edge.
  task automatic wait_ticks(input int n);
    int t;
    t = 0;
    while (t < n) begin
      if (m_div == SCAN_DIV - 1) t++;
      cycle();
    end
  endtask

  task automatic wait_col(input int c);
    int guard;
    guard = 0;
    wait_ticks(1);
    while (!(m_col == c && !m_locked) && guard < 16) begin
      wait_ticks(1);
      guard++;
    end
    checks++;
    if (guard >= 16) begin
      errors++; $display("FAIL wait_col: column %0d not reached within 16 ticks", c);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  // Tests
  task automatic test_reset();
    logic [3:0] seq [4];
    seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    reset = 1'b0;
    cycle();
    checks++;
    if (col !== 4'b1110 || key !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got col=%b key=%h v=%b h=%b expected 1110 0 0 0", col, key, key_valid, key_held);
    end
    reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cycle();
      if (i % 4 == 0) begin
        checks++;
        if (col !== seq[i/4 - 1]) begin
          errors++; $display("FAIL reset_scan: got %b expected %b", col, seq[i/4 - 1]);
        end
      end
    end
  endtask

  task automatic test_press_release();
    int p0;
    wait_col(2);
    p0 = pulses;
    set_key(1, 2, 1);
    wait_ticks(3);
    checks++;
    if (key_valid !== 1'b1 || key !== 4'h6 || key_held !== 1'b1 || col !== 4'b1011) begin
      errors++;
      $display("FAIL press_accept: got v=%b key=%h h=%b col=%b expected 1 6 1 1011", key_valid, key, key_held, col);
    end
    cycle();
    checks++;
    if (key_valid !== 1'b0) begin
      errors++; $display("FAIL press_single_pulse: got %b expected 0", key_valid);
    end
    set_key(1, 2, 0);
    wait_ticks(3);
    checks++;
    if (key_held !== 1'b0 || col !== 4'b0111 || pulses != p0 + 1) begin
      errors++;
      $display("FAIL press_release: got h=%b col=%b pulses=%0d expected 0 0111 %0d", key_held, col, pulses, p0 + 1);
    end
  endtask

  task automatic test_bounce();
    int p0;
    do_reset();
    wait_col(0);
    p0 = pulses;
    set_key(0, 0, 1);
    wait_ticks(2);
    set_key(0, 0, 0);
    wait_ticks(1);
    checks++;
    if (col !== 4'b1101 || key !== 4'h0 || pulses != p0) begin
      errors++;
      $display("FAIL bounce: got col=%b key=%h pulses=%0d expected 1101 0 %0d", col, key, pulses, p0);
    end
  endtask

  task automatic test_chatter();
    int p0;
    wait_col(1);
    p0 = pulses;
    set_key(3, 1, 1);
    wait_ticks(3);
    set_key(3, 1, 0);
    wait_ticks(1);
    set_key(3, 1, 1);
    wait_ticks(3);
    checks++;
    if (key_held !== 1'b1 || key !== 4'h0 || pulses != p0 + 1) begin
      errors++;
      $display("FAIL chatter_held: got h=%b key=%h pulses=%0d expected 1 0 %0d", key_held, key, pulses, p0 + 1);
    end
    set_key(3, 1, 0);
    wait_ticks(3);
    wait_col(1);
    set_key(3, 1, 1);
    wait_ticks(3);
    checks++;
    if (key_valid !== 1'b1 || key !== 4'h0 || pulses != p0 + 2) begin
      errors++;
      $display("FAIL chatter_second: got v=%b key=%h pulses=%0d expected 1 0 %0d", key_valid, key, pulses, p0 + 2);
    end
    set_key(3, 1, 0);
    wait_ticks(3);
  endtask

  task automatic test_simultaneous();
    int p0;
    wait_col(0);
    set_key(0, 0, 1);
    set_key(2, 0, 1);
    wait_ticks(3);
    checks++;
    if (key !== 4'h1 || key_held !== 1'b1) begin
      errors++; $display("FAIL simul_lowest_row: got key=%h h=%b expected 1 1", key, key_held);
    end
    p0 = pulses;
    set_key(2, 3, 1);
    wait_ticks(8);
    checks++;
    if (pulses != p0 || key !== 4'h1) begin
      errors++; $display("FAIL simul_ignore: got pulses=%0d key=%h expected %0d 1", pulses, key, p0);
    end
    release_all();
    wait_ticks(4);
  endtask

  task automatic test_reset_in_held();
    int p0, guard;
    wait_col(2);
    set_key(2, 2, 1);
    wait_ticks(4);
    checks++;
    if (key !== 4'h9 || key_held !== 1'b1) begin
      errors++; $display("FAIL held_pre_reset: got key=%h h=%b expected 9 1", key, key_held);
    end
    p0 = pulses;
    do_reset();
    checks++;
    if (key !== 4'h0 || key_held !== 1'b0 || col !== 4'b1110) begin
      errors++;
      $display("FAIL held_reset: got key=%h h=%b col=%b expected 0 0 1110", key, key_held, col);
    end
    guard = 0;
    while (pulses == p0 && guard < 100) begin
      cycle();
      guard++;
    end
    checks++;
    if (pulses != p0 + 1 || key !== 4'h9) begin
      errors++; $display("FAIL held_redetect: got pulses=%0d key=%h expected %0d 9", pulses, key, p0 + 1);
    end
    release_all();
    wait_ticks(4);
  endtask

  task automatic test_random();
    int nk;
    for (int it = 0; it < 20; it++) begin
      release_all();
      nk = $urandom_range(0, 2);
      for (int k = 0; k < nk; k++)
        set_key($urandom_range(0, 3), $urandom_range(0, 3), 1);
      wait_ticks($urandom_range(1, 6));
      if ($urandom_range(0, 1) == 1) begin
        release_all();
        wait_ticks($urandom_range(1, 2));
        for (int k = 0; k < nk; k++)
          set_key($urandom_range(0, 3), $urandom_range(0, 3), 1);
        wait_ticks($urandom_range(1, 6));
      end
      release_all();
      wait_ticks($urandom_range(1, 5));
    end
    release_all();
    wait_ticks(8);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL random_drain: got %0d pending keys expected 0", exp_q.size());
    end
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Main sequence and final report
  initial begin
    model_reset();
    release_all();
    check_en = 1'b1;
    test_reset();
    test_press_release();
    test_bounce();
    test_chatter();
    test_simultaneous();
    test_reset_in_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad and returns one debounced hex key code per press.
- It is the input-side counterpart of the hex-to-seven-segment display path: physical key in, 4-bit hex value plus a one-cycle strobe out.
- key_valid has the same single-cycle pulse format as the push signals from our button debouncers, so it can feed counter/load logic directly.

Parameters:
- SCAN_DIV, 1000, clk cycles per scan tick (column dwell time); legal range >= 4.
- DEBOUNCE_CNT, 8, consecutive stable scan ticks needed to accept a press or a release; legal range >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col  output  4  keypad column drive, active-low, exactly one bit low at all times
- key  output  4  hex code of the last accepted key; holds its value until the next accepted press
- key_valid  output  1  one-cycle pulse when a press is accepted
- key_held  output  1  high from acceptance until the release is debounced

Behaviour:
- Reset (reset==0 at a clk edge):
  - col=4'b1110, key=0, key_valid=0, key_held=0.
  - state=SCAN, col_idx=0, divider=0, debounce count=0.
  - Applies from any state, including mid-debounce and HELD.
- row passes through a 2-flop synchronizer. All decisions use the synchronized row, sampled only on a tick.
- Divider counts 0..SCAN_DIV-1. A tick is the cycle where the divider equals SCAN_DIV-1. The divider free-runs in every state.
- col = ~(4'b0001 << col_idx). col changes only on the edge after a tick.
- State machine, evaluated on ticks only:
  - SCAN:
    - No row low: col_idx increments, wrapping 3 to 0.
    - Any row low: capture col_idx and the lowest-indexed low row, set cnt=1, go to DEBOUNCE. Column freezes.
  - DEBOUNCE:
    - Captured row still low: cnt++.
    - When cnt reaches DEBOUNCE_CNT: key=code(row,col), key_valid=1 for exactly one clk, key_held=1, go to HELD.
    - Captured row high: cnt=0, col_idx++, go to SCAN. No output change.
    - If DEBOUNCE_CNT==1, acceptance happens directly from the SCAN tick that detects the press.
  - HELD:
    - Captured row high: cnt=1, go to RELEASE.
    - Otherwise stay.
  - RELEASE:
    - Captured row high: cnt++.
    - When cnt reaches DEBOUNCE_CNT: key_held=0, col_idx++, go to SCAN.
    - Captured row low again: go to HELD. No new key_valid.
- Only the captured row/column pair is watched while frozen. Other keys pressed during DEBOUNCE, HELD or RELEASE are ignored.
- Key map, code(row,col):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- key_valid is registered and is never high for two consecutive cycles.
- key is never updated without a key_valid pulse.

Decomposition:
- Shared package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, HELD, RELEASE}
  - 16-entry key-map constant, indexed by {row,col}
  - default SCAN_DIV / DEBOUNCE_CNT values
- One sub-module, sync2 (4-bit two-flop synchronizer), reusable for other asynchronous inputs.
- Divider, FSM and key map stay in keypad_scanner.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=3.
1. Reset with no keys pressed:
   - col=1110, key=0, key_valid=0, key_held=0.
   - col then cycles 1101, 1011, 0111, 1110, changing every 4 clks.
2. Hold r1/c2 (model drives row[1] low while col[2]==0):
   - Scan freezes at col=1011.
   - After 3 stable ticks: exactly one key_valid pulse with key=6, key_held=1.
   - Release: key_held=0 after 3 high ticks, then scanning resumes at col=0111.
3. Bounce on r0/c0, low for only 2 ticks:
   - No key_valid, key stays 0.
   - Scanning resumes with col=1101.
4. Chatter during HELD on r3/c1, row high for 1 tick then low again:
   - Single pulse with key=0; key_held stays 1.
   - After a full release and a second press: a second pulse, key=0.
5. Simultaneous r0 and r2 in column 0:
   - key=1, since the lowest row wins.
   - Pressing r2/c3 while r0/c0 is held produces no pulse.
6. reset=0 for one clk while in HELD with key=9:
   - Next edge: key=0, key_held=0, col=1110.
   - With the key still held, the key is re-detected and a fresh key_valid with key=9 follows.
